// File: rtl/data_io_pkg.sv
// Shared opcodes, state/phase enums and helpers for the data_io SPI initiator.
// The CRC helper is only used when DATA_IO_MASTER_CRC_EN is defined.
package data_io_pkg;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
  localparam logic [7:0] TX_START_ARG    = 8'hFF;
  localparam logic [7:0] TX_END_ARG      = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_GAP,
    ST_DATA_WAIT,
    ST_DATA,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_INDEX,
    PH_TXS,
    PH_DAT,
    PH_TXE
  } phase_t;

  function automatic logic [7:0] phase_opcode(input phase_t ph);
    logic [7:0] op;
    case (ph)
      PH_INDEX: op = UIO_FILE_INDEX;
      PH_DAT:   op = UIO_FILE_TX_DAT;
      default:  op = UIO_FILE_TX;
    endcase
    return op;
  endfunction

  function automatic logic [7:0] phase_arg(input phase_t ph, input logic [7:0] idx);
    logic [7:0] arg;
    case (ph)
      PH_INDEX: arg = idx;
      PH_TXS:   arg = TX_START_ARG;
      default:  arg = TX_END_ARG;
    endcase
    return arg;
  endfunction

  // CRC-16/CCITT, poly 0x1021, MSB first, no reflection.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc_in,
                                                   input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0 byte shifter: SCK low then high for CLK_DIV clocks per half, MSB first.
// last_edge pulses for one cycle after the 8th SCK falling edge.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       last_edge,
  output logic       sck,
  output logic       di
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic [6:0] shreg;
  logic [2:0] bits_left;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy      <= 1'b0;
      last_edge <= 1'b0;
      sck       <= 1'b0;
      di        <= 1'b0;
      div_cnt   <= 8'd0;
      shreg     <= 7'd0;
      bits_left <= 3'd0;
    end else begin
      last_edge <= 1'b0;
      if (load && !busy) begin
        busy      <= 1'b1;
        sck       <= 1'b0;
        di        <= data[7];
        shreg     <= data[6:0];
        bits_left <= 3'd7;
        div_cnt   <= DIV_LOAD;
      end else if (busy) begin
        if (div_cnt != 8'd0) begin
          div_cnt <= div_cnt - 8'd1;
        end else begin
          div_cnt <= DIV_LOAD;
          if (!sck) begin
            sck <= 1'b1;
          end else begin
            // DI only moves on the falling edge so the receiver sees it stable at the rise.
            sck <= 1'b0;
            if (bits_left == 3'd0) begin
              busy      <= 1'b0;
              last_edge <= 1'b1;
            end else begin
              di        <= shreg[6];
              shreg     <= {shreg[5:0], 1'b0};
              bits_left <= bits_left - 3'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/data_io_spi_master.sv
// Host-side initiator for the data_io file-download protocol (INDEX, TX start, TX_DAT, TX end).
// Define DATA_IO_MASTER_CRC_EN to add the crc output (CRC-16/CCITT of the payload).
module data_io_spi_master
  import data_io_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  index,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic        busy,
  output logic        done,
  output logic        spi_sck,
  output logic        spi_ss2,
  output logic        spi_di
`ifdef DATA_IO_MASTER_CRC_EN
  , output logic [15:0] crc
`endif
);

  // state        | meaning
  // ST_IDLE      | waiting for start, SS2 high
  // ST_GAP       | SS2 high for GAP_CYCLES before the next command
  // ST_CMD       | shifting the phase opcode
  // ST_ARG       | shifting the phase argument (INDEX/TXS/TXE)
  // ST_DATA_WAIT | SS2 low, s_ready high, SCK stalled until a byte arrives
  // ST_DATA      | shifting one payload byte
  // ST_DONE      | end command finished, pulse done next cycle

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

  state_t      state;
  phase_t      phase;
  logic [7:0]  idx_r;
  logic [15:0] gap_cnt;
  logic        last_r;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_last_edge;

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .load      (tx_load),
    .data      (tx_data),
    .busy      (tx_busy),
    .last_edge (tx_last_edge),
    .sck       (spi_sck),
    .di        (spi_di)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= ST_IDLE;
      phase   <= PH_INDEX;
      idx_r   <= 8'd0;
      gap_cnt <= 16'd0;
      last_r  <= 1'b0;
      tx_load <= 1'b0;
      tx_data <= 8'd0;
      spi_ss2 <= 1'b1;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx_r   <= index;
            busy    <= 1'b1;
            phase   <= PH_INDEX;
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
          end else if (!tx_busy) begin
            spi_ss2 <= 1'b0;
            tx_load <= 1'b1;
            tx_data <= phase_opcode(phase);
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (tx_last_edge) begin
            if (phase == PH_DAT) begin
              s_ready <= 1'b1;
              state   <= ST_DATA_WAIT;
            end else begin
              tx_load <= 1'b1;
              tx_data <= phase_arg(phase, idx_r);
              state   <= ST_ARG;
            end
          end
        end
        ST_ARG: begin
          if (tx_last_edge) begin
            spi_ss2 <= 1'b1;
            gap_cnt <= GAP_LOAD;
            case (phase)
              PH_INDEX: begin
                phase <= PH_TXS;
                state <= ST_GAP;
              end
              PH_TXS: begin
                phase <= PH_DAT;
                state <= ST_GAP;
              end
              default: state <= ST_DONE;
            endcase
          end
        end
        ST_DATA_WAIT: begin
          // SCK stays low here indefinitely; data_io is clocked by SCK so a stall is harmless.
          if (s_valid && s_ready) begin
            s_ready <= 1'b0;
            tx_load <= 1'b1;
            tx_data <= s_data;
            last_r  <= s_last;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_last_edge) begin
            if (last_r) begin
              spi_ss2 <= 1'b1;
              gap_cnt <= GAP_LOAD;
              phase   <= PH_TXE;
              state   <= ST_GAP;
            end else begin
              s_ready <= 1'b1;
              state   <= ST_DATA_WAIT;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DATA_IO_MASTER_CRC_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      crc <= 16'hFFFF;
    end else if (state == ST_IDLE && start) begin
      crc <= 16'hFFFF;
    end else if (state == ST_DATA_WAIT && s_valid && s_ready) begin
      crc <= crc16_ccitt_byte(crc, s_data);
    end
  end
`endif

endmodule

// File: tb/tb_data_io_spi_master.sv
// Self-checking bench for data_io_spi_master: SPI frame monitor, data_io receiver model, CRC golden model.
// Build with DATA_IO_MASTER_CRC_EN defined to also check the crc output.
module tb_data_io_spi_master;

  localparam int CLK_DIV_C = 2;
  localparam int GAP_C     = 4;
  localparam int BUDGET    = 5000;

  typedef logic [7:0] bq_t[$];

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [7:0]  index   = 8'd0;
  logic [7:0]  s_data  = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last  = 1'b0;
  logic        busy;
  logic        done;
  logic        spi_sck;
  logic        spi_ss2;
  logic        spi_di;
`ifdef DATA_IO_MASTER_CRC_EN
  logic [15:0] crc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  data_io_spi_master #(
    .CLK_DIV    (CLK_DIV_C),
    .GAP_CYCLES (GAP_C)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start),
    .index   (index),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .busy    (busy),
    .done    (done),
    .spi_sck (spi_sck),
    .spi_ss2 (spi_ss2),
    .spi_di  (spi_di)
`ifdef DATA_IO_MASTER_CRC_EN
    , .crc   (crc)
`endif
  );

  // ---------------- SPI monitor and data_io receiver model ----------------
  logic [7:0] cur_frame[$];
  logic [7:0] byte_q[$];
  int         frame_len_q[$];
  logic [7:0] exp_bytes[$];
  int         exp_len_q[$];

  int         cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int         hi_run = 0, lo_run = 0, ss2_hi_run = GAP_C;
  int         bitcnt = 0, tmg_err = 0, done_cnt = 0;
  logic       first_bit = 1'b0, byte_open = 1'b0;
  logic       prev_sck = 1'b0, prev_ss2 = 1'b1, prev_di = 1'b0;
  logic [7:0] sh = 8'd0;
  logic       dl = 1'b0;
  logic [7:0] io_index = 8'd0;
  int         wr_cnt = 0;

  always @(posedge clk_sys) begin
    #1;
    cyc++;
    if (reset) begin
      bitcnt = 0;
      cur_frame.delete();
      byte_open = 1'b0;
      ss2_hi_run = GAP_C;
    end else begin
      if (done) begin
        done_cnt++;
        if (busy) tmg_err++;
      end
      if (spi_ss2 && spi_sck != prev_sck) tmg_err++;
      if (spi_di != prev_di && spi_sck) tmg_err++;
      if (!spi_ss2 && prev_ss2) begin
        if (ss2_hi_run < GAP_C) tmg_err++;
        fall_cyc  = cyc;
        first_bit = 1'b1;
        bitcnt    = 0;
        cur_frame.delete();
      end
      if (spi_ss2) ss2_hi_run++;
      else ss2_hi_run = 0;
      if (!spi_ss2) begin
        if (spi_sck && !prev_sck) begin
          if (first_bit) begin
            if (cyc - fall_cyc != 1 + CLK_DIV_C) tmg_err++;
            first_bit = 1'b0;
          end else if (bitcnt != 0 && lo_run != CLK_DIV_C) begin
            tmg_err++;
          end
          if (bitcnt == 0) rise_cyc = cyc;
          sh = {sh[6:0], spi_di};
          bitcnt++;
          if (bitcnt == 8) begin
            cur_frame.push_back(sh);
            bitcnt    = 0;
            byte_open = 1'b1;
          end
          hi_run = 1;
        end else if (!spi_sck && prev_sck) begin
          if (hi_run != CLK_DIV_C) tmg_err++;
          if (byte_open && bitcnt == 0) begin
            if (cyc - rise_cyc != 15 * CLK_DIV_C) tmg_err++;
            byte_open = 1'b0;
          end
          lo_run = 1;
        end else if (spi_sck) begin
          hi_run++;
        end else begin
          lo_run++;
        end
      end
      if (spi_ss2 && !prev_ss2) begin
        if (bitcnt != 0) tmg_err++;
        frame_len_q.push_back(cur_frame.size());
        foreach (cur_frame[i]) byte_q.push_back(cur_frame[i]);
        if (cur_frame.size() >= 2) begin
          case (cur_frame[0])
            8'h55: io_index = cur_frame[1];
            8'h53: dl = (cur_frame[1] == 8'hFF);
            8'h54: if (dl) wr_cnt += cur_frame.size() - 1;
            default: tmg_err++;
          endcase
        end
      end
    end
    prev_sck = spi_sck;
    prev_ss2 = spi_ss2;
    prev_di  = spi_di;
  end

  // ---------------- reference model and helpers ----------------
  logic [15:0] crc_tab[256];

  function automatic logic [15:0] crc_model(input bq_t p);
    logic [15:0] c = 16'hFFFF;
    foreach (p[i]) c = (c << 8) ^ crc_tab[c[15:8] ^ p[i]];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_seq(input logic [7:0] idx, input bq_t pay);
    exp_len_q.push_back(2); exp_bytes.push_back(8'h55); exp_bytes.push_back(idx);
    exp_len_q.push_back(2); exp_bytes.push_back(8'h53); exp_bytes.push_back(8'hFF);
    exp_len_q.push_back(pay.size() + 1); exp_bytes.push_back(8'h54);
    foreach (pay[i]) exp_bytes.push_back(pay[i]);
    exp_len_q.push_back(2); exp_bytes.push_back(8'h53); exp_bytes.push_back(8'h00);
  endtask

  task automatic clear_mon();
    byte_q.delete();
    frame_len_q.delete();
    exp_bytes.delete();
    exp_len_q.delete();
    done_cnt = 0;
    wr_cnt   = 0;
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nframes"}, 32'(frame_len_q.size()), 32'(exp_len_q.size()));
    for (int i = 0; i < frame_len_q.size() && i < exp_len_q.size(); i++)
      chk($sformatf("%s_len%0d", tag, i), 32'(frame_len_q[i]), 32'(exp_len_q[i]));
    chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < byte_q.size() && i < exp_bytes.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_bytes[i]));
  endtask

  task automatic pulse_start(input logic [7:0] idx);
    index = idx;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int pre_gap);
    int n = 0;
    s_valid = 1'b0;
    repeat (pre_gap) @(negedge clk_sys);
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (!s_ready && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    chk("hs_ready", 32'(s_ready), 32'd1);
    @(negedge clk_sys);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_payload(input bq_t pay, input bit rnd);
    foreach (pay[i])
      send_byte(pay[i], (i == pay.size() - 1), rnd ? int'($urandom_range(0, 20)) : 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bq_t pay, pay2;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] c = 16'(i) << 8;
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      crc_tab[i] = c;
    end

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_ss2", 32'(spi_ss2), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_di", 32'(spi_di), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef DATA_IO_MASTER_CRC_EN
    chk("rst_crc", 32'(crc), 32'hFFFF);
`endif

    // single byte with s_valid held high
    clear_mon();
    pay = '{8'hA5};
    expect_seq(8'h03, pay);
    pulse_start(8'h03);
    chk("busy_after_start", 32'(busy), 32'd1);
    send_payload(pay, 1'b0);
    wait_done();
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    repeat (5) @(negedge clk_sys);
    check_frames("t1");
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_io_index", 32'(io_index), 32'h03);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("t1_dl_off", 32'(dl), 32'd0);
`ifdef DATA_IO_MASTER_CRC_EN
    chk("t1_crc", 32'(crc), 32'(crc_model(pay)));
`endif

    // 256-byte ramp with random stalls and a stray start while busy
    clear_mon();
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i));
    expect_seq(8'h03, pay);
    pulse_start(8'h03);
    repeat (2) @(negedge clk_sys);
    pulse_start(8'h77);
    send_payload(pay, 1'b1);
    wait_done();
    repeat (100) @(negedge clk_sys);
    check_frames("t2");
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_io_index", 32'(io_index), 32'h03);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd256);
`ifdef DATA_IO_MASTER_CRC_EN
    chk("t2_crc", 32'(crc), 32'(crc_model(pay)));
`endif

    // "123456789" then a back-to-back start on the cycle after done
    clear_mon();
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    expect_seq(8'h10, pay);
    pulse_start(8'h10);
    send_payload(pay, 1'b0);
    wait_done();
`ifdef DATA_IO_MASTER_CRC_EN
    chk("t3_crc_check", 32'(crc), 32'h29B1);
`endif
    @(negedge clk_sys);
    pay2.delete();
    for (int i = 0; i < 3; i++) pay2.push_back(8'($urandom));
    expect_seq(8'h22, pay2);
    pulse_start(8'h22);
    chk("t3_b2b_busy", 32'(busy), 32'd1);
    send_payload(pay2, 1'b1);
    wait_done();
    repeat (5) @(negedge clk_sys);
    check_frames("t3");
    chk("t3_done_cnt", 32'(done_cnt), 32'd2);
    chk("t3_io_index", 32'(io_index), 32'h22);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd12);
`ifdef DATA_IO_MASTER_CRC_EN
    chk("t3_crc2", 32'(crc), 32'(crc_model(pay2)));
`endif

    // reset during the second payload byte
    clear_mon();
    exp_len_q.push_back(2); exp_bytes.push_back(8'h55); exp_bytes.push_back(8'h03);
    exp_len_q.push_back(2); exp_bytes.push_back(8'h53); exp_bytes.push_back(8'hFF);
    pulse_start(8'h03);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    repeat (6) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("t4_ss2", 32'(spi_ss2), 32'd1);
    chk("t4_sck", 32'(spi_sck), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(s_ready), 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clk_sys);
    check_frames("t4");
    chk("t4_done_cnt", 32'(done_cnt), 32'd0);
    chk("t4_dl_still_on", 32'(dl), 32'd1);

    // full sequence after the abort
    clear_mon();
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
    expect_seq(8'h03, pay);
    pulse_start(8'h03);
    send_payload(pay, 1'b1);
    wait_done();
    repeat (5) @(negedge clk_sys);
    check_frames("t5");
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd5);
    chk("t5_dl_off", 32'(dl), 32'd0);
`ifdef DATA_IO_MASTER_CRC_EN
    chk("t5_crc", 32'(crc), 32'(crc_model(pay)));
`endif

    chk("spi_timing", 32'(tmg_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
